// File: rtl/zdraw_engine.sv
// zdraw_engine: turns FILL/HLINE/VLINE/RECT commands into single-pixel RGB565 writes on the SDRAM write port.
// Define ZDRAW_CLIP_EN to clamp commands to the framebuffer; out-of-range commands then complete with no writes.
module zdraw_engine #(
    parameter int unsigned       H_RES   = 480,
    parameter int unsigned       V_RES   = 800,
    parameter int unsigned       COORD_W = 10,
    parameter int unsigned       ADDR_W  = 24,
    parameter logic [ADDR_W-1:0] FB_BASE = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               iCmd_Valid,
    output logic               oCmd_Ready,
    input  logic [1:0]         iCmd_Op,
    input  logic [COORD_W-1:0] iCmd_X0,
    input  logic [COORD_W-1:0] iCmd_Y0,
    input  logic [COORD_W-1:0] iCmd_X1,
    input  logic [COORD_W-1:0] iCmd_Y1,
    input  logic [15:0]        iCmd_Color,
    output logic [ADDR_W-1:0]  oSDRAM_Wr_Addr,
    output logic [15:0]        oSDRAM_Wr_Data,
    output logic               oSDRAM_Wr_Req,
    input  logic               iSDRAM_Wr_Done,
    output logic               oDraw_Done,
    output logic               oBusy
);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_WRITE, S_ADV, S_DONE} state_t;
    typedef enum logic [1:0] {OP_FILL, OP_HLINE, OP_VLINE, OP_RECT} op_t;

    localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_RES);

    if (((64'd1 << COORD_W) < 64'(H_RES)) || ((64'd1 << COORD_W) < 64'(V_RES))) begin : g_cfg_check
        $error("zdraw_engine: COORD_W too narrow for H_RES/V_RES");
    end

`ifdef ZDRAW_CLIP_EN
    localparam logic [COORD_W:0] X_MAX = (COORD_W+1)'(H_RES - 1);
    localparam logic [COORD_W:0] Y_MAX = (COORD_W+1)'(V_RES - 1);
`endif

    state_t             state;
    op_t                op_q;
    logic [15:0]        color_q;
    logic [COORD_W-1:0] x0_q, x1_q, y0_q, y1_q, row_q, cnt_q;
    logic [1:0]         phase_q;
    logic               empty_q;

    logic [COORD_W-1:0] cx1, cy1, sx0, sx1, sy0, sy1;
    logic               cmd_empty;
    logic [COORD_W-1:0] dy, run_x, run_y, run_len;
    logic               run_vert, has_next;
    logic [1:0]         next_phase;
    logic [ADDR_W-1:0]  run_addr;

    // HLINE ignores Y1 and VLINE ignores X1 by folding them onto the start coordinate before sorting.
    always_comb begin
        cx1 = (op_t'(iCmd_Op) == OP_VLINE) ? iCmd_X0 : iCmd_X1;
        cy1 = (op_t'(iCmd_Op) == OP_HLINE) ? iCmd_Y0 : iCmd_Y1;
        sx0 = (iCmd_X0 < cx1) ? iCmd_X0 : cx1;
        sx1 = (iCmd_X0 < cx1) ? cx1 : iCmd_X0;
        sy0 = (iCmd_Y0 < cy1) ? iCmd_Y0 : cy1;
        sy1 = (iCmd_Y0 < cy1) ? cy1 : iCmd_Y0;
`ifdef ZDRAW_CLIP_EN
        if ({1'b0, sx1} > X_MAX) sx1 = X_MAX[COORD_W-1:0];
        if ({1'b0, sy1} > Y_MAX) sy1 = Y_MAX[COORD_W-1:0];
        cmd_empty = ({1'b0, sx0} > X_MAX) || ({1'b0, sy0} > Y_MAX);
`else
        cmd_empty = 1'b0;
`endif
    end

    // Current run (row, line or RECT edge) and what follows it.
    always_comb begin
        dy         = y1_q - y0_q;
        run_x      = x0_q;
        run_y      = y0_q;
        run_len    = x1_q - x0_q;
        run_vert   = 1'b0;
        has_next   = 1'b0;
        next_phase = phase_q + 2'd1;
        case (op_q)
            OP_FILL: begin
                run_y    = row_q;
                has_next = (row_q != y1_q);
            end
            OP_VLINE: begin
                run_len  = dy;
                run_vert = 1'b1;
            end
            OP_RECT: begin
                case (phase_q)
                    2'd0: has_next = (dy != '0);
                    2'd1: begin
                        run_y    = y1_q;
                        has_next = |dy[COORD_W-1:1];
                    end
                    2'd2: begin
                        run_y    = y0_q + COORD_W'(1);
                        run_len  = dy - COORD_W'(2);
                        run_vert = 1'b1;
                        has_next = (x1_q != x0_q);
                    end
                    default: begin
                        run_x    = x1_q;
                        run_y    = y0_q + COORD_W'(1);
                        run_len  = dy - COORD_W'(2);
                        run_vert = 1'b1;
                    end
                endcase
            end
            default: ;
        endcase
        run_addr = FB_BASE + ADDR_W'(run_y) * H_STEP + ADDR_W'(run_x);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            op_q           <= OP_FILL;
            color_q        <= '0;
            x0_q           <= '0;
            x1_q           <= '0;
            y0_q           <= '0;
            y1_q           <= '0;
            row_q          <= '0;
            cnt_q          <= '0;
            phase_q        <= '0;
            empty_q        <= 1'b0;
            oCmd_Ready     <= 1'b1;
            oBusy          <= 1'b0;
            oDraw_Done     <= 1'b0;
            oSDRAM_Wr_Req  <= 1'b0;
            oSDRAM_Wr_Addr <= '0;
            oSDRAM_Wr_Data <= '0;
        end else if (en) begin
            case (state)
                S_IDLE: begin
                    if (iCmd_Valid) begin
                        op_q       <= op_t'(iCmd_Op);
                        color_q    <= iCmd_Color;
                        x0_q       <= sx0;
                        x1_q       <= sx1;
                        y0_q       <= sy0;
                        y1_q       <= sy1;
                        row_q      <= sy0;
                        phase_q    <= '0;
                        empty_q    <= cmd_empty;
                        oCmd_Ready <= 1'b0;
                        oBusy      <= 1'b1;
                        state      <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (empty_q) begin
                        oDraw_Done <= 1'b1;
                        state      <= S_DONE;
                    end else begin
                        oSDRAM_Wr_Addr <= run_addr;
                        oSDRAM_Wr_Data <= color_q;
                        cnt_q          <= run_len;
                        oSDRAM_Wr_Req  <= 1'b1;
                        state          <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (iSDRAM_Wr_Done) begin
                        oSDRAM_Wr_Req <= 1'b0;
                        state         <= S_ADV;
                    end
                end
                S_ADV: begin
                    if (cnt_q != '0) begin
                        cnt_q          <= cnt_q - COORD_W'(1);
                        oSDRAM_Wr_Addr <= oSDRAM_Wr_Addr + (run_vert ? H_STEP : ADDR_W'(1));
                        oSDRAM_Wr_Req  <= 1'b1;
                        state          <= S_WRITE;
                    end else if (has_next) begin
                        phase_q <= next_phase;
                        row_q   <= row_q + COORD_W'(1);
                        state   <= S_SETUP;
                    end else begin
                        oDraw_Done <= 1'b1;
                        state      <= S_DONE;
                    end
                end
                S_DONE: begin
                    oDraw_Done <= 1'b0;
                    oBusy      <= 1'b0;
                    oCmd_Ready <= 1'b1;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/zdraw_engine.md
# zdraw_engine

Parametrised framebuffer drawing engine that converts primitive commands into single-pixel RGB565 writes on the SDRAM write port. It accepts one command at a time: rectangle fill, horizontal line, vertical line or rectangle outline, each with its own colour. It generates row-major framebuffer addresses for a configurable resolution. It sits between the display/control logic (command source) and the SDRAM controller write port, in the same position as the fixed-pattern drawer it supersedes.

## Interface
- `H_RES`, 480, framebuffer width in pixels (row stride).
- `V_RES`, 800, framebuffer height in pixels.
- `COORD_W`, 10, coordinate width; it must satisfy `2^COORD_W >= max(H_RES, V_RES)`.
- `ADDR_W`, 24, SDRAM word address width (Bank+Row+Column).
- `FB_BASE`, 0, word address of pixel (0,0).
- Clock and reset: one clock, `clk`. Reset is asynchronous and active-low, `rst_n`.
- `clk` in 1: system clock; all logic runs on the rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `en` in 1: global enable. When low, the FSM and all outputs freeze.
- `iCmd_Valid` in 1: a command is present on the `iCmd_*` inputs.
- `oCmd_Ready` out 1: the engine is idle and accepts a command.
- `iCmd_Op` in 2: 0=FILL, 1=HLINE, 2=VLINE, 3=RECT.
- `iCmd_X0`, `iCmd_Y0`, `iCmd_X1`, `iCmd_Y1` in COORD_W each: corner coordinates, inclusive.
- `iCmd_Color` in 16: RGB565 pixel value.
- `oSDRAM_Wr_Addr` out ADDR_W: pixel write address.
- `oSDRAM_Wr_Data` out 16: pixel write data.
- `oSDRAM_Wr_Req` out 1: write request, level signal.
- `iSDRAM_Wr_Done` in 1: write accepted by the SDRAM controller.
- `oDraw_Done` out 1: one-cycle pulse when a command completes.
- `oBusy` out 1: a command is in progress.

## Operation
- Reset values: `oSDRAM_Wr_Addr`=0, `oSDRAM_Wr_Data`=0, `oSDRAM_Wr_Req`=0, `oDraw_Done`=0, `oBusy`=0, `oCmd_Ready`=1. The FSM resets to IDLE.
- Command accept: `oCmd_Ready` is high only in IDLE. A command is accepted on a cycle where `iCmd_Valid & oCmd_Ready & en` is true. On acceptance, the op, the colour and the sorted corners are latched: `x0<=min(X0,X1)`, `x1<=max(X0,X1)`, and the same for y.
- Primitives:
  - FILL writes all pixels in `[x0..x1]×[y0..y1]`, row by row, left to right.
  - HLINE writes row y0, `x0..x1`. The Y1 input is ignored.
  - VLINE writes column x0, `y0..y1`. The X1 input is ignored.
  - RECT writes four edges in this order: top (y0, x0..x1), bottom (y1, x0..x1), left (x0, y0+1..y1-1), right (x1, y0+1..y1-1). No pixel is written twice. The bottom edge is skipped if y0==y1. The left and right edges are skipped if y1-y0<2. The right edge is skipped if x0==x1.
- Address arithmetic:
  - The start address of each run is `FB_BASE + y*H_RES + x`, computed once per run in the SETUP state with a constant multiply.
  - Within a run, the address steps +1 for horizontal runs and +H_RES for vertical runs.
  - All sums are ADDR_W wide and wrap modulo 2^ADDR_W.
- FSM states: IDLE → SETUP → WRITE ⇄ ADV → (next row or edge: SETUP) → DONE → IDLE.
- SDRAM handshake:
  - In WRITE, `oSDRAM_Wr_Req`=1 with addr and data held stable until `iSDRAM_Wr_Done` is sampled high.
  - In that same cycle the FSM moves to ADV and Req drops.
  - ADV lasts exactly one cycle with Req=0. It either steps to the next pixel and returns to WRITE, or goes to SETUP or DONE.
  - `iSDRAM_Wr_Done` is ignored outside WRITE.
- `en`=0: no state, counter or output changes, and `iSDRAM_Wr_Done` is ignored. The command source drops `en` only while the engine is in IDLE.
- Reset mid-command: the command is discarded, no `oDraw_Done` pulse is produced, and the engine returns to the reset values.

## Timing
- With acceptance at cycle A:
  - SETUP occupies cycle A+1.
  - Req rises at the clock edge ending A+1, so Req is first high in cycle A+2.
- Per pixel: Req is high until Done is sampled (minimum one cycle), then Req is low for exactly one cycle. Minimum throughput is 2 cycles per pixel, plus one SETUP cycle per row or edge.
- `oDraw_Done` is high for one cycle (state DONE), which is the cycle after the ADV of the last pixel. `oCmd_Ready` returns high in the following cycle.
- A zero-pixel command (see Configuration) pulses `oDraw_Done` in cycle A+2.
- `oBusy` is high from A+1 through the DONE cycle, inclusive.

## Configuration
- `ZDRAW_CLIP_EN` defined:
  - After sorting, x1 is clamped to H_RES-1 and y1 is clamped to V_RES-1.
  - If x0≥H_RES or y0≥V_RES, the command performs zero writes and completes via DONE.
  - RECT edge-skip rules are evaluated on the clamped corners.
- `ZDRAW_CLIP_EN` undefined: no clamping. Out-of-range coordinates produce raw wrapped addresses, and the caller guarantees in-range commands.

## Test plan
- FILL (0,0)-(479,799), colour 0x0000 → 384000 writes, addresses 0..383999 ascending, one `oDraw_Done` pulse.
- HLINE X0=470, X1=10, Y0=10, colour 0xFFE0 (swapped X) → 461 writes at addresses 4810..5270 ascending.
- VLINE X0=10, Y0=10, Y1=790 → 781 writes at 4810, 5290, …, 379210 (step 480). Done is held low for 3 cycles per write and each write completes.
- RECT (10,10)-(470,790) → 2480 writes in the order top/bottom/left/right, addresses unique, corners written once. RECT (5,5)-(5,5) → exactly 1 write at 2405.
- With `ZDRAW_CLIP_EN`: HLINE X0=470, X1=600, Y0=0 → 10 writes at 470..479. HLINE X0=500 → 0 writes, `oDraw_Done` in cycle A+2.
- Assert `rst_n`=0 during pixel 100 of a FILL → all outputs return to their reset values immediately, no `oDraw_Done` pulse. A new command accepted after reset executes correctly.
